// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mixer
//  Description : Sound-effect mixer for the 1-bit tone generators. Detects
//                which sources are sounding from their toggles, picks one
//                by fixed priority (index 0 highest), inserts a silent gap
//                after the selected effect ends, then applies mute and an
//                8-step PWM volume before driving the speaker pin.
//
//  Ports       : clk        - system clock
//                reset      - synchronous, active-high reset
//                src_in     - square-wave tone inputs (clk domain)
//                mute       - forces audio_out low, arbitration continues
//                volume     - PWM duty in eighths (0 silent, 8..15 full)
//                audio_out  - registered speaker drive
//                sel_valid  - a source is selected (state PLAY)
//                sel_idx    - index of the selected source
//
//  Options     : AUDIO_MIXER_XOR_EN - when defined, PLAY outputs the XOR of
//                all active sources instead of only the selected one.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_mixer #(
    parameter int NUM_SRC     = 4,
    parameter int ACT_TIMEOUT = 400000,
    parameter int GAP_CYCLES  = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_in,
    input  logic                       mute,
    input  logic [3:0]                 volume,
    output logic                       audio_out,
    output logic                       sel_valid,
    output logic [$clog2(NUM_SRC)-1:0] sel_idx
);

    localparam int c_SEL_W = $clog2(NUM_SRC);
    localparam int c_ACT_W = $clog2(ACT_TIMEOUT + 1);
    localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_ACT_W-1:0] c_ACT_LOAD = c_ACT_W'(ACT_TIMEOUT);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PLAY = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [NUM_SRC-1:0] r_src_q;
    logic               r_primed;
    logic [1:0]         r_state;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [2:0]         r_pwm_cnt;
    logic               r_audio;
    logic               r_sel_valid;
    logic [c_SEL_W-1:0] r_sel_idx;

    logic [NUM_SRC-1:0] w_tog;
    logic [NUM_SRC-1:0] w_active;
    logic [c_SEL_W-1:0] w_best;
    logic               w_none;
    logic [1:0]         w_state_nxt;
    logic [c_SEL_W-1:0] w_sel_nxt;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic               w_pwm_on;
    logic               w_tone;
    logic               w_audio_nxt;

    // src_q is cleared by reset, so the first edge after reset would see a
    // false toggle on any input that happens to sit high. r_primed masks
    // that one edge so a stuck-high line cannot reselect a source.
    assign w_tog = (src_in ^ r_src_q) & {NUM_SRC{r_primed}};

    // Per-source activity timer: reloaded on every toggle, saturates at 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_act
            logic [c_ACT_W-1:0] r_act_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_act_cnt <= '0;
                end else if (w_tog[gi]) begin
                    r_act_cnt <= c_ACT_LOAD;
                end else if (r_act_cnt != '0) begin
                    r_act_cnt <= r_act_cnt - c_ACT_W'(1);
                end
            end

            assign w_active[gi] = (r_act_cnt != '0);
        end
    endgenerate

    // Lowest active index wins; scanning downward lets the last hit stand.
    always_comb begin
        w_best = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_best = c_SEL_W'(i);
            end
        end
    end

    assign w_none = ~|w_active;

    // Arbitration. A dying selected source takes precedence over any
    // preemption on the same edge, so the gap is always honoured.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_idx;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            c_IDLE: begin
                if (!w_none) begin
                    w_state_nxt = c_PLAY;
                    w_sel_nxt   = w_best;
                end
            end
            c_PLAY: begin
                if (!w_active[r_sel_idx]) begin
                    if (GAP_CYCLES == 0) begin
                        // No gap configured: behave as IDLE on this edge.
                        if (w_none) begin
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_sel_nxt = w_best;
                        end
                    end else begin
                        w_state_nxt = c_GAP;
                        w_gap_nxt   = c_GAP_LOAD;
                    end
                end else if (w_best < r_sel_idx) begin
                    w_sel_nxt = w_best;
                end
            end
            c_GAP: begin
                w_gap_nxt = r_gap_cnt - c_GAP_W'(1);
                if (r_gap_cnt <= c_GAP_W'(1)) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_pwm_on = ({1'b0, r_pwm_cnt} < volume);

`ifdef AUDIO_MIXER_XOR_EN
    // Overlapping effects are mixed; selection still gates PLAY.
    assign w_tone = ^(r_src_q & w_active);
`else
    assign w_tone = r_src_q[r_sel_idx];
`endif

    assign w_audio_nxt = (r_state == c_PLAY) & w_tone & w_pwm_on & ~mute;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_q     <= '0;
            r_primed    <= 1'b0;
            r_state     <= c_IDLE;
            r_gap_cnt   <= '0;
            r_pwm_cnt   <= 3'd0;
            r_audio     <= 1'b0;
            r_sel_valid <= 1'b0;
            r_sel_idx   <= '0;
        end else begin
            r_src_q     <= src_in;
            r_primed    <= 1'b1;
            r_state     <= w_state_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_pwm_cnt   <= r_pwm_cnt + 3'd1;
            r_audio     <= w_audio_nxt;
            r_sel_valid <= (w_state_nxt == c_PLAY);
            r_sel_idx   <= w_sel_nxt;
        end
    end

    assign audio_out = r_audio;
    assign sel_valid = r_sel_valid;
    assign sel_idx   = r_sel_idx;

endmodule
`default_nettype wire
